// File: rtl/requant_pipeline_pkg.sv
// Shared definitions for the requantization pipeline: output clamp modes and
// the values every channel's config entry takes out of reset.
package requant_pipeline_pkg;

  typedef enum logic {
    QMODE_INT8 = 1'b0,
    QMODE_WIDE = 1'b1
  } qmode_e;

  localparam int DEF_SCALE = 1;
  localparam int DEF_SHIFT = 0;
  localparam int DEF_ZP    = 0;

endpackage

// File: rtl/requant_sat.sv
// Combinational clamp of a wide signed value to int8 or OUT_W-bit signed range,
// flagging whether the clamp changed the value.
module requant_sat
  import requant_pipeline_pkg::*;
#(
  parameter int IN_W  = 49,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_val,
  input  qmode_e                  i_mode,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);

  localparam logic signed [IN_W-1:0] MAX_WIDE = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MAX_INT8 = {{(IN_W-7){1'b0}}, 7'h7f};

  logic signed [IN_W-1:0] w_hi;
  logic signed [IN_W-1:0] w_lo;
  logic signed [IN_W-1:0] w_clamp;

  // Lower bound is the bitwise complement of the upper bound (-2^(b-1)).
  always_comb begin
    w_hi    = (i_mode == QMODE_WIDE) ? MAX_WIDE : MAX_INT8;
    w_lo    = ~w_hi;
    w_clamp = i_val;
    o_sat   = 1'b0;
    if (i_val > w_hi) begin
      w_clamp = w_hi;
      o_sat   = 1'b1;
    end else if (i_val < w_lo) begin
      w_clamp = w_lo;
      o_sat   = 1'b1;
    end
  end

  assign o_val = OUT_W'(w_clamp);

endmodule

// File: rtl/requant_pipeline.sv
// Three-stage per-channel requantizer: multiply by channel scale, round-shift,
// add zero point and saturate, with valid/ready back-pressure on every stage.
module requant_pipeline
  import requant_pipeline_pkg::*;
#(
  parameter  int IN_W    = 32,
  parameter  int SCALE_W = 16,
  parameter  int OUT_W   = 16,
  parameter  int CH      = 8,
  parameter  int SHIFT_W = 5,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = $clog2(CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [IN_W-1:0]    s_data,
  input  logic [CH_W-1:0]           s_chan,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic signed [OUT_W-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  input  logic                      out_mode,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_chan,
  input  logic signed [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic signed [OUT_W-1:0]   cfg_zp,
  output logic [CNT_W-1:0]          sat_cnt,
  input  logic                      sat_clr
);

  localparam int P_W = IN_W + SCALE_W;

  // Round half up then arithmetic shift; one guard bit absorbs the bias carry.
  function automatic logic signed [P_W-1:0] round_shift(input logic signed [P_W-1:0] x,
                                                        input logic [SHIFT_W-1:0]  sh);
    logic signed [P_W:0] ext;
    logic signed [P_W:0] bias;
    if (sh == '0) return x;
    bias               = '0;
    bias[sh - 1'b1]    = 1'b1;
    ext                = {x[P_W-1], x} + bias;
    return P_W'(ext >>> sh);
  endfunction

  logic signed [SCALE_W-1:0] r_scale [CH];
  logic [SHIFT_W-1:0]        r_shift [CH];
  logic signed [OUT_W-1:0]   r_zp    [CH];

  // Reads in S1 see the pre-write entry, so a same-cycle write lands on the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_scale[i] <= SCALE_W'(DEF_SCALE);
        r_shift[i] <= SHIFT_W'(DEF_SHIFT);
        r_zp[i]    <= OUT_W'(DEF_ZP);
      end
    end else if (cfg_we) begin
      r_scale[cfg_chan] <= cfg_scale;
      r_shift[cfg_chan] <= cfg_shift;
      r_zp[cfg_chan]    <= cfg_zp;
    end
  end

  logic                      w_adv;
  logic signed [P_W-1:0]     w_prod_p0;
  logic signed [P_W-1:0]     r_prod_p1;
  logic [SHIFT_W-1:0]        r_shift_p1;
  logic signed [OUT_W-1:0]   r_zp_p1;
  qmode_e                    r_mode_p1;
  logic                      r_vld_p1;
  logic signed [P_W-1:0]     r_rnd_p2;
  logic signed [OUT_W-1:0]   r_zp_p2;
  qmode_e                    r_mode_p2;
  logic                      r_vld_p2;
  logic signed [P_W:0]       w_sum_p2;
  logic signed [OUT_W-1:0]   w_q_p2;
  logic                      w_sat_p2;
  logic signed [OUT_W-1:0]   r_data_p3;
  logic                      r_sat_p3;
  logic                      r_vld_p3;
  logic [CNT_W-1:0]          r_sat_cnt;

  assign w_adv   = !r_vld_p3 || m_ready;
  assign s_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= s_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // ---- S0 -> S1: table lookup and multiply
  assign w_prod_p0 = P_W'(s_data) * P_W'(r_scale[s_chan]);

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_prod_p1  <= w_prod_p0;
      r_shift_p1 <= r_shift[s_chan];
      r_zp_p1    <= r_zp[s_chan];
      r_mode_p1  <= qmode_e'(out_mode);
      // ---- S1 -> S2: rounding shift
      r_rnd_p2   <= round_shift(r_prod_p1, r_shift_p1);
      r_zp_p2    <= r_zp_p1;
      r_mode_p2  <= r_mode_p1;
    end
  end

  // ---- S2 -> S3: zero-point offset and saturation
  assign w_sum_p2 = (P_W+1)'(r_rnd_p2) + (P_W+1)'(r_zp_p2);

  requant_sat #(
    .IN_W  (P_W + 1),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_val  (w_sum_p2),
    .i_mode (r_mode_p2),
    .o_val  (w_q_p2),
    .o_sat  (w_sat_p2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p3 <= '0;
      r_sat_p3  <= 1'b0;
    end else if (w_adv) begin
      r_data_p3 <= w_q_p2;
      r_sat_p3  <= w_sat_p2;
    end
  end

  // Clear takes priority over a coincident saturation event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_vld_p3 && m_ready && r_sat_p3 && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign m_data  = r_data_p3;
  assign m_valid = r_vld_p3;
  assign sat_cnt = r_sat_cnt;

endmodule
